// File: rtl/instr_sequencer_if.sv
// Bus bundle between the TinyChip instruction sequencer and its surroundings:
// imem/dmem handshakes, decoded control strobes, PC and status.
interface instr_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             run;
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack;
    logic [8:0]       imem_data;
    logic [8:0]       ir;
    logic             alu_src_imm;
    logic             rf_we;
    logic             rf_wsel;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             cond_eq;
    logic [PC_W-1:0]  pc;
    logic             busy;
    logic             halted;
    logic             bus_err;
    logic [CNT_W-1:0] retired;

    // Sequencer side
    modport master (
        input  run, imem_ack, imem_data, dmem_ack, cond_eq,
        output imem_req, imem_addr, ir, alu_src_imm, rf_we, rf_wsel,
               dmem_req, dmem_we, pc, busy, halted, bus_err, retired
    );

    // Memory / datapath / control side
    modport slave (
        output run, imem_ack, imem_data, dmem_ack, cond_eq,
        input  imem_req, imem_addr, ir, alu_src_imm, rf_we, rf_wsel,
               dmem_req, dmem_we, pc, busy, halted, bus_err, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// TinyChip fetch/decode/execute sequencer. Owns PC and IR, sequences register
// writes and data-memory accesses, watches both bus handshakes for timeouts and
// counts retired instructions.
//
// state  | meaning
// IDLE   | waiting for run; pc retained
// FETCH  | imem_req high until imem_ack (or timeout)
// DECODE | one cycle, latch operand-2 select from ir
// EXEC   | branch / ALU write / halt resolve, or launch memory access
// MEM    | dmem_req high until dmem_ack (or timeout)
// WB     | load data written to register file
// HALT   | stopped after halt instruction; run=0 returns to IDLE
// ERR    | bus timeout, sticky until reset
module instr_sequencer #(
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic clk_i,
    input logic rst_i,
    instr_sequencer_if.master bus
);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    state_t             state_q;
    logic [PC_W-1:0]    pc_q;
    logic [8:0]         ir_q;
    logic [CNT_W-1:0]   retired_q;
    logic [WAIT_W-1:0]  wait_q;
    logic               imem_req_q;
    logic               dmem_req_q;
    logic               dmem_we_q;
    logic               rf_we_q;
    logic               rf_wsel_q;
    logic               alu_src_imm_q;

    logic               bit_type;
    logic [2:0]         opcode;
    logic               is_branch;
    logic               is_mem;
    logic               is_halt;
    logic               br_taken;
    logic [PC_W-1:0]    pc_inc_d;
    logic [PC_W-1:0]    pc_br_d;
    logic [CNT_W-1:0]   retired_d;

    assign bit_type  = ir_q[8];
    assign opcode    = ir_q[7:5];
    assign is_branch = bit_type && (opcode == 3'b010 || opcode == 3'b011);
    assign is_mem    = bit_type && (opcode == 3'b100 || opcode == 3'b101);
    assign is_halt   = !bit_type && (opcode == 3'b111);
    // beq takes on equality, bne on inequality
    assign br_taken  = (opcode == 3'b010) ? bus.cond_eq : !bus.cond_eq;
    assign pc_inc_d  = pc_q + PC_W'(1);
    assign pc_br_d   = pc_q + (br_taken ? PC_W'(2) : PC_W'(1));
    assign retired_d = (&retired_q) ? retired_q : retired_q + CNT_W'(1);

    // Sequencer FSM with registered strobes, PC, IR, watchdog and retire counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            retired_q     <= '0;
            wait_q        <= '0;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_wsel_q     <= 1'b0;
            alu_src_imm_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.run) begin
                        state_q    <= S_FETCH;
                        imem_req_q <= 1'b1;
                        wait_q     <= '0;
                    end
                end
                S_FETCH: begin
                    // an ack on the final allowed cycle still counts
                    if (bus.imem_ack) begin
                        ir_q       <= bus.imem_data;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end else if (wait_q == WAIT_LAST) begin
                        imem_req_q <= 1'b0;
                        state_q    <= S_ERR;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    alu_src_imm_q <= ir_q[8];
                    state_q       <= S_EXEC;
                    if (!is_branch && !is_mem && !is_halt) begin
                        rf_we_q   <= 1'b1;
                        rf_wsel_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    rf_we_q <= 1'b0;
                    if (is_branch) begin
                        pc_q       <= pc_br_d;
                        retired_q  <= retired_d;
                        imem_req_q <= 1'b1;
                        wait_q     <= '0;
                        state_q    <= S_FETCH;
                    end else if (is_mem) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (opcode == 3'b101);
                        wait_q     <= '0;
                        state_q    <= S_MEM;
                    end else if (is_halt) begin
                        retired_q <= retired_d;
                        state_q   <= S_HALT;
                    end else begin
                        pc_q       <= pc_inc_d;
                        retired_q  <= retired_d;
                        imem_req_q <= 1'b1;
                        wait_q     <= '0;
                        state_q    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dmem_we_q) begin
                            pc_q       <= pc_inc_d;
                            retired_q  <= retired_d;
                            imem_req_q <= 1'b1;
                            wait_q     <= '0;
                            state_q    <= S_FETCH;
                        end else begin
                            rf_we_q   <= 1'b1;
                            rf_wsel_q <= 1'b1;
                            state_q   <= S_WB;
                        end
                    end else if (wait_q == WAIT_LAST) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        state_q    <= S_ERR;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_WB: begin
                    rf_we_q    <= 1'b0;
                    rf_wsel_q  <= 1'b0;
                    pc_q       <= pc_inc_d;
                    retired_q  <= retired_d;
                    imem_req_q <= 1'b1;
                    wait_q     <= '0;
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                    if (!bus.run) begin
                        state_q <= S_IDLE;
                    end
                end
                S_ERR: begin
                    state_q <= S_ERR;
                end
                default: begin
                    state_q <= S_ERR;
                end
            endcase
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.ir          = ir_q;
    assign bus.alu_src_imm = alu_src_imm_q;
    assign bus.rf_we       = rf_we_q;
    assign bus.rf_wsel     = rf_wsel_q;
    assign bus.dmem_req    = dmem_req_q;
    assign bus.dmem_we     = dmem_we_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_ERR);
    assign bus.halted      = (state_q == S_HALT);
    assign bus.bus_err     = (state_q == S_ERR);
    assign bus.retired     = retired_q;
endmodule
